// File: rtl/control_sequencer_pkg.sv
// Shared opcode, control-bit and fetch-word constants for the sequencer.
// Imported by microcode_rom and control_sequencer.
package control_sequencer_pkg;

    localparam int OPCODE_WIDTH = 4;
    localparam int CW_WIDTH     = 16;
    localparam int STEP_WIDTH   = 3;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int CW_HLT = 15;
    localparam int CW_MI  = 14;
    localparam int CW_RI  = 13;
    localparam int CW_RO  = 12;
    localparam int CW_IO  = 11;
    localparam int CW_II  = 10;
    localparam int CW_AI  = 9;
    localparam int CW_AO  = 8;
    localparam int CW_EO  = 7;
    localparam int CW_SU  = 6;
    localparam int CW_BI  = 5;
    localparam int CW_OI  = 4;
    localparam int CW_CE  = 3;
    localparam int CW_CO  = 2;
    localparam int CW_J   = 1;
    localparam int CW_FI  = 0;

    localparam logic [15:0] CW_FETCH0 = 16'h4004;
    localparam logic [15:0] CW_FETCH1 = 16'h1408;
    localparam logic [15:0] CW_HALTED = 16'h8000;

endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// Combinational microcode: (opcode, step, flags) -> control word, last step.
// Ports: opcode, step, carry_flag, zero_flag in; control_word, last_step out.
module microcode_rom
    import control_sequencer_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [2:0]  step,
    input  logic        carry_flag,
    input  logic        zero_flag,
    output logic [15:0] control_word,
    output logic [2:0]  last_step
);

    always_comb begin
        control_word = '0;
        last_step    = 3'd1;

        case (opcode)
            OP_LDA, OP_STA: last_step = 3'd3;
            OP_ADD, OP_SUB: last_step = 3'd4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ,
            OP_OUT, OP_HLT: last_step = 3'd2;
            default:        last_step = 3'd1;
        endcase

        case (step)
            3'd0: control_word = CW_FETCH0;
            3'd1: control_word = CW_FETCH1;
            3'd2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        control_word[CW_IO] = 1'b1;
                        control_word[CW_MI] = 1'b1;
                    end
                    OP_LDI: begin
                        control_word[CW_IO] = 1'b1;
                        control_word[CW_AI] = 1'b1;
                    end
                    OP_JMP: begin
                        control_word[CW_IO] = 1'b1;
                        control_word[CW_J]  = 1'b1;
                    end
                    // Conditional jumps read the live flags, no latching.
                    OP_JC: begin
                        control_word[CW_IO] = carry_flag;
                        control_word[CW_J]  = carry_flag;
                    end
                    OP_JZ: begin
                        control_word[CW_IO] = zero_flag;
                        control_word[CW_J]  = zero_flag;
                    end
                    OP_OUT: begin
                        control_word[CW_AO] = 1'b1;
                        control_word[CW_OI] = 1'b1;
                    end
                    OP_HLT:  control_word[CW_HLT] = 1'b1;
                    default: control_word = '0;
                endcase
            end
            3'd3: begin
                case (opcode)
                    OP_LDA: begin
                        control_word[CW_RO] = 1'b1;
                        control_word[CW_AI] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        control_word[CW_RO] = 1'b1;
                        control_word[CW_BI] = 1'b1;
                    end
                    OP_STA: begin
                        control_word[CW_AO] = 1'b1;
                        control_word[CW_RI] = 1'b1;
                    end
                    default: control_word = '0;
                endcase
            end
            3'd4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    control_word[CW_EO] = 1'b1;
                    control_word[CW_AI] = 1'b1;
                    control_word[CW_FI] = 1'b1;
                    control_word[CW_SU] = (opcode == OP_SUB);
                end
            end
            default: control_word = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: T-state counter, halt latch and output override.
// Ports: clk, clr, opcode, carry_flag, zero_flag in; control_word, step, halted out.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  opcode,
    input  logic        carry_flag,
    input  logic        zero_flag,
    output logic [15:0] control_word,
    output logic [2:0]  step,
    output logic        halted
);

    logic [2:0]  step_q, step_d;
    logic        halted_q, halted_d;
    logic [15:0] rom_cw;
    logic [2:0]  last_step;

    microcode_rom u_rom (
        .opcode       (opcode),
        .step         (step_q),
        .carry_flag   (carry_flag),
        .zero_flag    (zero_flag),
        .control_word (rom_cw),
        .last_step    (last_step)
    );

    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (step_q == last_step) begin
                step_d = 3'd0;
            end else begin
                step_d = step_q + 3'd1;
            end
            if (opcode == OP_HLT && step_q == 3'd2) begin
                halted_d = 1'b1;
            end
        end
    end

    // Falling-edge state keeps control_word stable around rising edges.
    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            step_q   <= 3'd0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    assign control_word = clr      ? 16'h0000  :
                          halted_q ? CW_HALTED : rom_cw;
    assign step   = step_q;
    assign halted = halted_q;

endmodule
